// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_scanner
//  Purpose  : Rotating one-hot column scanner for a matrix keypad. It debounces
//             whole scans, rejects ghost presses and reports the encoded key.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module keypad_matrix_scanner #(
    parameter int N_COLS   = 4,
    parameter int N_ROWS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = $clog2(N_COLS * N_ROWS)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              en,
    input  logic [N_ROWS-1:0] row,
    output logic [N_COLS-1:0] col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int c_dwell_w = $clog2(SCAN_DIV);
    localparam int c_cidx_w  = $clog2(N_COLS);
    localparam int c_deb_w   = $clog2(DEBOUNCE + 1);

    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SCAN_DIV - 1);
    localparam logic [c_cidx_w-1:0]  c_col_last   = c_cidx_w'(N_COLS - 1);
    localparam logic [c_deb_w-1:0]   c_deb_max    = c_deb_w'(DEBOUNCE);
    localparam logic [c_deb_w-1:0]   c_deb_one    = c_deb_w'(1);

    // Scan result kinds; the code field is only meaningful for c_res_key.
    localparam logic [1:0] c_res_none  = 2'd0;
    localparam logic [1:0] c_res_key   = 2'd1;
    localparam logic [1:0] c_res_multi = 2'd2;

    logic [N_ROWS-1:0]    r_row_s1;
    logic [N_ROWS-1:0]    r_row_s2;
    logic                 r_run;
    logic [c_dwell_w-1:0] r_dwell;
    logic [c_cidx_w-1:0]  r_cidx;
    logic [1:0]           r_cnt;
    logic [CODE_W-1:0]    r_pos;
    logic [1:0]           r_prev_kind;
    logic [CODE_W-1:0]    r_prev_code;
    logic [c_deb_w-1:0]   r_deb;
    logic [CODE_W-1:0]    r_key_code;
    logic                 r_key_held;
    logic                 r_key_valid;

    logic                 w_sample;
    logic                 w_last_col;
    logic [1:0]           w_pop;
    logic [CODE_W-1:0]    w_hit_row;
    logic [2:0]           w_sum;
    logic [1:0]           w_tot;
    logic [CODE_W-1:0]    w_pos;
    logic [1:0]           w_res_kind;
    logic [CODE_W-1:0]    w_res_code;
    logic                 w_same;
    logic [c_deb_w-1:0]   w_deb_next;
    logic                 w_accept;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_row_s1 <= '0;
            r_row_s2 <= '0;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    always_comb begin
        col = '0;
        for (int c = 0; c < N_COLS; c++) begin
            col[c] = r_run && (r_cidx == c_cidx_w'(c));
        end
    end

    always_comb begin
        w_sample   = r_run && en && (r_dwell == c_dwell_last);
        w_last_col = (r_cidx == c_col_last);

        w_pop     = 2'd0;
        w_hit_row = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (r_row_s2[r]) begin
                if (w_pop != 2'd2) begin
                    w_pop = w_pop + 2'd1;
                end
                w_hit_row = CODE_W'(r);
            end
        end

        w_sum = {1'b0, r_cnt} + {1'b0, w_pop};
        w_tot = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_pos = (w_pop != 2'd0) ? (CODE_W'(r_cidx) * CODE_W'(N_ROWS) + w_hit_row) : r_pos;

        w_res_kind = c_res_multi;
        w_res_code = '0;
        if (w_tot == 2'd0) begin
            w_res_kind = c_res_none;
        end else if (w_tot == 2'd1) begin
            w_res_kind = c_res_key;
            w_res_code = w_pos;
        end

        w_same = (w_res_kind == r_prev_kind) && (w_res_code == r_prev_code);
        if (!w_same) begin
            w_deb_next = c_deb_one;
        end else if (r_deb == c_deb_max) begin
            w_deb_next = r_deb;
        end else begin
            w_deb_next = r_deb + c_deb_one;
        end
        w_accept = (w_deb_next == c_deb_max);
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_run       <= 1'b0;
            r_dwell     <= '0;
            r_cidx      <= '0;
            r_cnt       <= 2'd0;
            r_pos       <= '0;
            r_prev_kind <= c_res_none;
            r_prev_code <= '0;
            r_deb       <= '0;
            r_key_code  <= '0;
            r_key_held  <= 1'b0;
            r_key_valid <= 1'b0;
        end else if (!en) begin
            // Key state and the previous result survive a pause in scanning.
            r_run       <= 1'b0;
            r_dwell     <= '0;
            r_cidx      <= '0;
            r_cnt       <= 2'd0;
            r_pos       <= '0;
            r_deb       <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_key_valid <= 1'b0;
            if (r_run) begin
                if (r_dwell == c_dwell_last) begin
                    r_dwell <= '0;
                    r_cidx  <= w_last_col ? '0 : r_cidx + c_cidx_w'(1);
                end else begin
                    r_dwell <= r_dwell + c_dwell_w'(1);
                end
            end
            if (w_sample) begin
                if (w_last_col) begin
                    r_cnt <= 2'd0;
                    r_pos <= '0;
                    r_deb <= w_deb_next;
                    if (!w_same) begin
                        r_prev_kind <= w_res_kind;
                        r_prev_code <= w_res_code;
                    end
                    if (w_accept) begin
                        if (w_res_kind == c_res_key) begin
                            if (!r_key_held || (w_res_code != r_key_code)) begin
                                r_key_code  <= w_res_code;
                                r_key_held  <= 1'b1;
                                r_key_valid <= 1'b1;
                            end
                        end else if (w_res_kind == c_res_none) begin
                            r_key_held <= 1'b0;
                        end
                    end
                end else begin
                    r_cnt <= w_tot;
                    r_pos <= w_pos;
                end
            end
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire
